button_event_arbiter: RTL

Turns the debounced push-button levels of the board into a single stream of timestamp-free button events (press, long-press, auto-repeat, release) and hands them one at a time to the game/menu controller over a valid/ready handshake. It sits directly behind the per-button debouncers, in the same 100 Hz clock domain, and arbitrates fairly when several buttons produce events in the same window.

---
 rtl/btn_evt_pkg.sv | 16 +
 rtl/btn_evt_fsm.sv | 118 +++++++++++
 rtl/button_event_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event-kind codes and per-button FSM state encoding for the
// button event arbiter.
package btn_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_LONG    = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;
    localparam logic [1:0] EVT_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_REPT = 2'd2
    } btn_state_t;

endpackage

// File: rtl/btn_evt_fsm.sv
// One button: press/long/repeat/release FSM, hold counter and a single-entry
// pending slot that the arbiter drains through i_grant.
module btn_evt_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn,
    input  logic       i_grant,
    output logic       o_slot_valid,
    output logic [1:0] o_slot_kind,
    output logic       o_lost
);

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPT_LAST = CNT_W'(REPEAT_TICKS - 1);

    btn_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_slot_valid, w_slot_valid_next;
    logic [1:0]       r_slot_kind, w_slot_kind_next;
    logic             w_raise;
    logic [1:0]       w_raise_kind;
    logic             w_slot_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_slot_valid <= 1'b0;
            r_slot_kind  <= EVT_PRESS;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_slot_valid <= w_slot_valid_next;
            r_slot_kind  <= w_slot_kind_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_raise      = 1'b0;
        w_raise_kind = EVT_PRESS;
        case (r_state)
            ST_IDLE: begin
                if (i_btn) begin
                    w_raise      = 1'b1;
                    w_raise_kind = EVT_PRESS;
                    w_cnt_next   = '0;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!i_btn) begin
                    w_raise      = 1'b1;
                    w_raise_kind = EVT_RELEASE;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_raise      = 1'b1;
                    w_raise_kind = EVT_LONG;
                    w_cnt_next   = '0;
                    w_state_next = ST_REPT;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            ST_REPT: begin
                if (!i_btn) begin
                    w_raise      = 1'b1;
                    w_raise_kind = EVT_RELEASE;
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == REPT_LAST) begin
                    w_raise      = 1'b1;
                    w_raise_kind = EVT_REPEAT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // A grant on this edge frees the slot before the new event is considered.
    assign w_slot_left = r_slot_valid & ~i_grant;

    always_comb begin
        w_slot_valid_next = w_slot_left;
        w_slot_kind_next  = r_slot_kind;
        o_lost            = 1'b0;
        if (w_raise) begin
            if (!w_slot_left) begin
                w_slot_valid_next = 1'b1;
                w_slot_kind_next  = w_raise_kind;
            end else begin
                o_lost = 1'b1;
                if (w_raise_kind == EVT_RELEASE) begin
                    w_slot_kind_next = EVT_RELEASE;
                end
            end
        end
    end

    assign o_slot_valid = r_slot_valid;
    assign o_slot_kind  = r_slot_kind;

endmodule

// File: rtl/button_event_arbiter.sv
// Merges per-button events into one valid/ready stream with round-robin
// fairness; drop flags any event lost to a full pending slot.
module button_event_arbiter
    import btn_evt_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    localparam int BTN_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_db,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [BTN_W-1:0] evt_btn,
    output logic [1:0]       evt_kind,
    output logic             drop
);

    logic [N_BTN-1:0] w_slot_valid;
    logic [1:0]       w_slot_kind [N_BTN];
    logic [N_BTN-1:0] w_lost;
    logic [N_BTN-1:0] w_grant;

    logic             r_evt_valid;
    logic [BTN_W-1:0] r_evt_btn;
    logic [1:0]       r_evt_kind;
    logic             r_drop;
    logic [BTN_W-1:0] r_rr;

    logic             w_load;
    logic             w_take;
    logic             w_found;
    logic [BTN_W-1:0] w_gidx;
    logic [BTN_W-1:0] w_rr_next;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_evt_fsm #(
                .LONG_TICKS   (LONG_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS)
            ) u_fsm (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_btn        (btn_db[gi]),
                .i_grant      (w_grant[gi]),
                .o_slot_valid (w_slot_valid[gi]),
                .o_slot_kind  (w_slot_kind[gi]),
                .o_lost       (w_lost[gi])
            );
            assign w_grant[gi] = w_take && (w_gidx == BTN_W'(gi));
        end
    endgenerate

    // Search starts at the round-robin pointer and wraps once.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = r_rr;
        for (int k = 0; k < N_BTN; k++) begin
            int idx;
            idx = int'(r_rr) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!w_found && w_slot_valid[idx]) begin
                w_found = 1'b1;
                w_gidx  = BTN_W'(idx);
            end
        end
    end

    assign w_load    = ~r_evt_valid | evt_ready;
    assign w_take    = w_load & w_found;
    assign w_rr_next = (int'(w_gidx) == N_BTN - 1) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_btn   <= '0;
            r_evt_kind  <= EVT_PRESS;
            r_drop      <= 1'b0;
            r_rr        <= '0;
        end else begin
            r_drop <= |w_lost;
            if (w_take) begin
                r_evt_valid <= 1'b1;
                r_evt_btn   <= w_gidx;
                r_evt_kind  <= w_slot_kind[w_gidx];
                r_rr        <= w_rr_next;
            end else if (w_load) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_btn   = r_evt_btn;
    assign evt_kind  = r_evt_kind;
    assign drop      = r_drop;

endmodule
